// File: rtl/mux_rr_sequencer.sv
// -----------------------------------------------------------------------------
// mux_rr_sequencer
//
// Round-robin channel sequencer for a 4:1 multiplexer. It scans four request
// lines and steers the mux select to the next requesting channel after the
// last one served. It then waits DWELL settle cycles, captures the mux output
// and offers the captured sample on a valid/ready port.
//
// Parameters
//   DW        data width, equal to the mux data width
//   DWELL     settle cycles between a select change and the capture (1..255)
//
// Ports
//   i_clk     rising-edge clock
//   i_rst     asynchronous, active-high reset
//   i_req     per-channel request (bit i = mux input i)
//   i_x       mux output, a combinational function of o_sel
//   o_sel     registered mux select
//   o_dout    captured sample
//   o_dch     channel index of o_dout
//   o_dvalid  sample valid
//   i_dready  consumer accepts the sample when high together with o_dvalid
//   o_ovf     sticky drop flag
//
// Optional feature (macro MUX_SEQ_TIMEOUT_EN)
//   When the macro is defined, a sample is dropped after 16 HOLD cycles
//   without i_dready, and o_ovf is set until reset. When the macro is not
//   defined, HOLD waits indefinitely and o_ovf is tied low.
// -----------------------------------------------------------------------------
module mux_rr_sequencer #(
    parameter int DW    = 2,
    parameter int DWELL = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [3:0]    i_req,
    input  logic [DW-1:0] i_x,
    output logic [1:0]    o_sel,
    output logic [DW-1:0] o_dout,
    output logic [1:0]    o_dch,
    output logic          o_dvalid,
    input  logic          i_dready,
    output logic          o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // First requesting channel searching last+1, last+2, ... (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    state_t        r_state, w_state_nx;
    logic [1:0]    r_sel, w_sel_nx;
    logic [7:0]    r_cnt, w_cnt_nx;
    logic [DW-1:0] r_dout, w_dout_nx;
    logic [1:0]    r_dch, w_dch_nx;
    logic          r_dvalid, w_dvalid_nx;
    logic [1:0]    r_last, w_last_nx;
`ifdef MUX_SEQ_TIMEOUT_EN
    logic [3:0]    r_tmo, w_tmo_nx;
    logic          r_ovf, w_ovf_nx;
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'd0;
            r_cnt    <= 8'd0;
            r_dout   <= '0;
            r_dch    <= 2'd0;
            r_dvalid <= 1'b0;
            r_last   <= 2'd3;
`ifdef MUX_SEQ_TIMEOUT_EN
            r_tmo    <= 4'd0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_sel    <= w_sel_nx;
            r_cnt    <= w_cnt_nx;
            r_dout   <= w_dout_nx;
            r_dch    <= w_dch_nx;
            r_dvalid <= w_dvalid_nx;
            r_last   <= w_last_nx;
`ifdef MUX_SEQ_TIMEOUT_EN
            r_tmo    <= w_tmo_nx;
            r_ovf    <= w_ovf_nx;
`endif
        end
    end

    // Next-state and next-register logic; everything holds unless changed.
    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_cnt_nx    = r_cnt;
        w_dout_nx   = r_dout;
        w_dch_nx    = r_dch;
        w_dvalid_nx = r_dvalid;
        w_last_nx   = r_last;
`ifdef MUX_SEQ_TIMEOUT_EN
        w_tmo_nx    = r_tmo;
        w_ovf_nx    = r_ovf;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_req != 4'b0000) begin
                    w_sel_nx   = rr_pick(i_req, r_last);
                    w_cnt_nx   = 8'(DWELL - 1);
                    w_state_nx = S_SETTLE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_SETTLE: begin
                // The capture happens on the DWELL-th cycle after the select change.
                if (r_cnt == 8'd0) begin
                    w_dout_nx   = i_x;
                    w_dch_nx    = r_sel;
                    w_dvalid_nx = 1'b1;
`ifdef MUX_SEQ_TIMEOUT_EN
                    w_tmo_nx    = 4'd0;
`endif
                    w_state_nx  = S_HOLD;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (i_dready) begin
                    w_dvalid_nx = 1'b0;
                    w_last_nx   = r_sel;
                    w_state_nx  = S_IDLE;
                end else begin
`ifdef MUX_SEQ_TIMEOUT_EN
                    // The sixteenth stalled cycle drops the sample.
                    if (r_tmo == 4'd15) begin
                        w_dvalid_nx = 1'b0;
                        w_ovf_nx    = 1'b1;
                        w_last_nx   = r_sel;
                        w_state_nx  = S_IDLE;
                    end else begin
                        w_tmo_nx = r_tmo + 4'd1;
                    end
`else
                    w_state_nx = S_HOLD;
`endif
                end
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_dvalid_nx = 1'b0;
            end
        endcase
    end

    assign o_sel    = r_sel;
    assign o_dout   = r_dout;
    assign o_dch    = r_dch;
    assign o_dvalid = r_dvalid;
`ifdef MUX_SEQ_TIMEOUT_EN
    assign o_ovf    = r_ovf;
`else
    assign o_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_sequencer
//
// Self-checking bench for mux_rr_sequencer (DW=2, DWELL=4). A behavioural
// 4:1 mux (A=1, B=2, C=3, D=0) drives X from SEL. Expected samples are pushed
// to a queue when requests are driven, and they are compared with the samples
// that the DUT hands over. Honours MUX_SEQ_TIMEOUT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mux_rr_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] x;
    logic [1:0] sel;
    logic [1:0] dout;
    logic [1:0] dch;
    logic       dvalid;
    logic       dready;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [1:0] exp_ch[$];
    logic [1:0] exp_d[$];
    logic [1:0] obs_ch[$];
    logic [1:0] obs_d[$];
    int         obs_t[$];

    mux_rr_sequencer #(.DW(2), .DWELL(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_x      (x),
        .o_sel    (sel),
        .o_dout   (dout),
        .o_dch    (dch),
        .o_dvalid (dvalid),
        .i_dready (dready),
        .o_ovf    (ovf)
    );

    // Behavioural 4:1 mux with inputs A=1, B=2, C=3, D=0.
    always_comb begin
        case (sel)
            2'd0:    x = 2'd1;
            2'd1:    x = 2'd2;
            2'd2:    x = 2'd3;
            default: x = 2'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] mux_val(input logic [1:0] ch);
        case (ch)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Records every handshake (DVALID and DREADY both high at a negedge).
    task automatic collect(input int n, input int budget);
        int got;
        int k;
        got = 0;
        k   = 0;
        while (got < n && k < budget) begin
            @(negedge clk);
            k++;
            if (dvalid === 1'b1 && dready === 1'b1) begin
                obs_ch.push_back(dch);
                obs_d.push_back(dout);
                obs_t.push_back(cyc);
                got++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b0000; dready = 1'b0;
        #1;
        n_tests++;
        if ({sel, dout, dch, dvalid, ovf} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_values: got sel=%0d dout=%0d dch=%0d dvalid=%0b ovf=%0b, want all 0",
                     sel, dout, dch, dvalid, ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({sel, dvalid} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_release: got sel=%0d dvalid=%0b, want 0/0", sel, dvalid);
        end
    endtask

    // REQ=0100: SEL=2 one cycle later, sample C on channel 2 four cycles after that.
    task automatic test_single;
        req = 4'b0100; dready = 1'b1;
        exp_ch.push_back(2'd2); exp_d.push_back(mux_val(2'd2));
        @(negedge clk);
        req = 4'b0000;
        n_tests++;
        if (sel !== 2'd2) begin
            n_fail++;
            $display("FAIL single_sel: got %0d, want 2", sel);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (dvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early_valid: cycle %0d got dvalid=%0b, want 0", i + 1, dvalid);
            end
        end
        @(negedge clk);
        n_tests++;
        if (dvalid !== 1'b1 || dch !== exp_ch[0] || dout !== exp_d[0]) begin
            n_fail++;
            $display("FAIL single_sample: got v=%0b ch=%0d d=%0d, want v=1 ch=%0d d=%0d",
                     dvalid, dch, dout, exp_ch[0], exp_d[0]);
        end
        void'(exp_ch.pop_front()); void'(exp_d.pop_front());
        @(negedge clk);
        n_tests++;
        if (dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consumed: got dvalid=%0b, want 0", dvalid);
        end
    endtask

    // DREADY low for 10 HOLD cycles: sample and SEL must be held.
    task automatic test_hold_stall;
        int k;
        req = 4'b0001; dready = 1'b0;
        exp_ch.push_back(2'd0); exp_d.push_back(mux_val(2'd0));
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (dvalid !== 1'b1 && k < 12);
        req = 4'b0000;
        n_tests++;
        if (dvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_valid: got dvalid=%0b after %0d cycles, want 1", dvalid, k);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (dvalid !== 1'b1 || dout !== exp_d[0] || dch !== exp_ch[0] || sel !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got v=%0b d=%0d ch=%0d sel=%0d, want v=1 d=%0d ch=%0d sel=0",
                         i, dvalid, dout, dch, sel, exp_d[0], exp_ch[0]);
            end
        end
        dready = 1'b1;
        void'(exp_ch.pop_front()); void'(exp_d.pop_front());
        @(negedge clk);
        n_tests++;
        if (dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept: got dvalid=%0b, want 0 after first DREADY", dvalid);
        end
        @(negedge clk);
    endtask

    // After channel 1 served, REQ=1010 grants 3 and then 1.
    task automatic test_rr_skip;
        obs_ch.delete(); obs_d.delete(); obs_t.delete();
        dready = 1'b1;
        req = 4'b0010;
        exp_ch.push_back(2'd1); exp_d.push_back(mux_val(2'd1));
        collect(1, 20);
        req = 4'b1010;
        exp_ch.push_back(2'd3); exp_d.push_back(mux_val(2'd3));
        exp_ch.push_back(2'd1); exp_d.push_back(mux_val(2'd1));
        collect(2, 40);
        req = 4'b0000;
        n_tests++;
        if (obs_ch.size() != 3) begin
            n_fail++;
            $display("FAIL rr_count: got %0d samples, want 3", obs_ch.size());
        end
        while (obs_ch.size() > 0 && exp_ch.size() > 0) begin
            n_tests++;
            if (obs_ch[0] !== exp_ch[0] || obs_d[0] !== exp_d[0]) begin
                n_fail++;
                $display("FAIL rr_order: got ch=%0d d=%0d, want ch=%0d d=%0d",
                         obs_ch[0], obs_d[0], exp_ch[0], exp_d[0]);
            end
            void'(obs_ch.pop_front()); void'(obs_d.pop_front());
            void'(exp_ch.pop_front()); void'(exp_d.pop_front());
        end
        exp_ch.delete(); exp_d.delete();
        repeat (2) @(negedge clk);
    endtask

    // All requests high after reset: 0,1,2,3,0 with handshakes 6 cycles apart.
    task automatic test_back_to_back;
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs_ch.delete(); obs_d.delete(); obs_t.delete();
        dready = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_ch.push_back(order[i]); exp_d.push_back(mux_val(order[i]));
        end
        collect(5, 60);
        req = 4'b0000;
        n_tests++;
        if (obs_ch.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d samples, want 5", obs_ch.size());
        end
        for (int i = 1; i < obs_t.size(); i++) begin
            n_tests++;
            if (obs_t[i] - obs_t[i-1] != 6) begin
                n_fail++;
                $display("FAIL b2b_period: sample %0d got spacing %0d, want 6", i, obs_t[i] - obs_t[i-1]);
            end
        end
        while (obs_ch.size() > 0 && exp_ch.size() > 0) begin
            n_tests++;
            if (obs_ch[0] !== exp_ch[0] || obs_d[0] !== exp_d[0]) begin
                n_fail++;
                $display("FAIL b2b_order: got ch=%0d d=%0d, want ch=%0d d=%0d",
                         obs_ch[0], obs_d[0], exp_ch[0], exp_d[0]);
            end
            void'(obs_ch.pop_front()); void'(obs_d.pop_front());
            void'(exp_ch.pop_front()); void'(exp_d.pop_front());
        end
        exp_ch.delete(); exp_d.delete();
        repeat (2) @(negedge clk);
    endtask

    // Reset two cycles into SETTLE, then channel 0 must be served first again.
    task automatic test_reset_mid_settle;
        dready = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({sel, dout, dch, dvalid, ovf} !== 8'b0) begin
            n_fail++;
            $display("FAIL midreset_values: got sel=%0d dout=%0d dch=%0d dvalid=%0b ovf=%0b, want all 0",
                     sel, dout, dch, dvalid, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_discard: got dvalid=%0b, want 0", dvalid);
        end
        obs_ch.delete(); obs_d.delete(); obs_t.delete();
        req = 4'b1111;
        exp_ch.push_back(2'd0); exp_d.push_back(mux_val(2'd0));
        collect(1, 20);
        req = 4'b0000;
        n_tests++;
        if (obs_ch.size() != 1 || obs_ch[0] !== exp_ch[0] || obs_d[0] !== exp_d[0]) begin
            n_fail++;
            $display("FAIL midreset_first: got n=%0d ch=%0d d=%0d, want n=1 ch=%0d d=%0d",
                     obs_ch.size(), (obs_ch.size() > 0) ? obs_ch[0] : 2'd0,
                     (obs_d.size() > 0) ? obs_d[0] : 2'd0, exp_ch[0], exp_d[0]);
        end
        exp_ch.delete(); exp_d.delete();
        repeat (2) @(negedge clk);
    endtask

    // Stalled consumer: drop after 16 cycles with the macro, wait forever without.
    task automatic test_timeout;
        int k;
        int high;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dready = 1'b0;
        req = 4'b0011;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (dvalid !== 1'b1 && k < 12);
        n_tests++;
        if (dvalid !== 1'b1 || dch !== 2'd0) begin
            n_fail++;
            $display("FAIL tmo_first: got v=%0b ch=%0d, want v=1 ch=0", dvalid, dch);
        end
`ifdef MUX_SEQ_TIMEOUT_EN
        high = 1;
        while (dvalid === 1'b1 && high < 40) begin
            @(negedge clk);
            if (dvalid === 1'b1) high++;
        end
        n_tests++;
        if (high != 16 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_drop: got %0d valid cycles ovf=%0b, want 16 and 1", high, ovf);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (dvalid !== 1'b1 && k < 12);
        n_tests++;
        if (dvalid !== 1'b1 || dch !== 2'd1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_next: got v=%0b ch=%0d ovf=%0b, want v=1 ch=1 ovf=1", dvalid, dch, ovf);
        end
`else
        high = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dvalid === 1'b1 && ovf === 1'b0 && dch === 2'd0) high++;
        end
        n_tests++;
        if (high != 20) begin
            n_fail++;
            $display("FAIL notmo_hold: got %0d of 20 cycles valid with ovf=0, want 20", high);
        end
`endif
        req = 4'b0000;
        dready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_end: got dvalid=%0b, want 0", dvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_stall();
        test_rr_skip();
        test_back_to_back();
        test_reset_mid_settle();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_sequencer.md
# mux_rr_sequencer

Round-robin channel sequencer that drives the select input of the 4:1 `multiplexer` and captures its output. It scans four request lines, steers `SEL` to the next requesting channel, waits a programmable settle time, samples the mux output `X`, and presents the sample on a valid/ready port to the downstream consumer.

## Interface
- `DW`, 2, data width; must equal the mux data width.
- `DWELL`, 4, settle cycles between a `SEL` change and the capture of `X`; legal range 1..255.
- `CLK`  input  1  rising-edge clock.
- `RST`  input  1  asynchronous, active-high reset.
- `REQ`  input  4  per-channel request; bit i requests a sample of mux input i (A=0, B=1, C=2, D=3).
- `X`  input  DW  mux output, combinationally dependent on `SEL`.
- `SEL`  output  2  registered select to the mux.
- `DOUT`  output  DW  captured sample.
- `DCH`  output  2  channel index of `DOUT`.
- `DVALID`  output  1  sample valid.
- `DREADY`  input  1  consumer accepts the sample when high together with `DVALID`.
- `OVF`  output  1  sticky drop flag (see Configuration).

## Operation
- One clock domain. Reset is asynchronous and active-high.
- Reset values: `SEL`=0, `DOUT`=0, `DCH`=0, `DVALID`=0, `OVF`=0, state IDLE, last-served pointer `LAST`=3, so channel 0 has top priority after reset.
- States:
  - IDLE: if `REQ`≠0, select the first set bit searching `LAST+1`, `LAST+2`, … (mod 4); load `SEL` and `CNT`=`DWELL`-1; go to SETTLE. If `REQ`=0, stay in IDLE and hold `SEL`.
  - SETTLE: if `CNT`=0, load `DOUT`←`X`, `DCH`←`SEL`, `DVALID`←1, and go to HOLD. Otherwise decrement `CNT`.
  - HOLD: if `DREADY`=1, clear `DVALID`, set `LAST`←`SEL`, and go to IDLE.
- `REQ` is sampled only in IDLE. Deasserting a request during SETTLE or HOLD does not abort the transfer.
- `DOUT` and `DCH` are stable while `DVALID`=1. `SEL` does not change outside the IDLE→SETTLE transition.
- Fairness: with all four requests held high, channels are served in the order 0,1,2,3,0,…
- `RST` asserted in any state returns all outputs to their reset values immediately. A pending sample is discarded.

## Timing
- `REQ` seen at edge k in IDLE: `SEL` is updated at edge k+1 and `DVALID` rises at edge k+1+`DWELL`. With `DWELL`=4, `DVALID` rises 5 cycles after the request is seen.
- SETTLE lasts exactly `DWELL` cycles.
- When `DREADY` is held high, HOLD lasts 1 cycle and the next IDLE decision occurs 1 cycle later. Back-to-back service period is `DWELL`+2 cycles.
- A handshake on the same cycle `DVALID` first rises counts; the sample is consumed at the following edge.
- No combinational path from `DREADY` or `REQ` to any output.

## Configuration
- Macro: `MUX_SEQ_TIMEOUT_EN`.
- Defined: an 4-bit counter in HOLD counts cycles with `DREADY`=0. After 16 such cycles, `DVALID` is cleared, `OVF` is set (sticky until `RST`), `LAST`←`SEL`, and the FSM returns to IDLE. The counter clears on HOLD entry.
- Undefined: HOLD waits indefinitely for `DREADY`, and `OVF` is tied to 0.

## Test plan
- Reset mid-SETTLE (`REQ`=4'b0001, `RST` pulsed 2 cycles after `SEL` load) -> all outputs 0 immediately, IDLE, and channel 0 served again first after release.
- A=1, B=2, C=3, D=0, `REQ`=4'b1111, `DREADY`=1, `DWELL`=4 -> `DCH`/`DOUT` sequence 0/1, 1/2, 2/3, 3/0, 0/1, with `DVALID` pulses 6 cycles apart.
- `REQ`=4'b0100 only -> `SEL`=2 one cycle after the request is seen; `DVALID`=1, `DOUT`=C, and `DCH`=2 four cycles later.
- `REQ`=4'b1010 after channel 1 served -> next grant is channel 3, then channel 1.
- `DREADY`=0 for 10 cycles during HOLD -> `DVALID` and `DOUT` held constant, `SEL` unchanged, and accepted on the first `DREADY`=1.
- With `MUX_SEQ_TIMEOUT_EN`, `DREADY`=0 -> `DVALID` drops after 16 HOLD cycles, `OVF`=1 and stays 1, and the next channel is served. Without the macro, `DVALID` stays high and `OVF`=0.
